// File: rtl/uart_rx.sv
// uart_rx -- serial receive front end for the LED demo path.
//
// Receives 8N1 frames, LSB first, from an RXD line that has already been
// synchronized into the clk_rx domain. A free-running baud enable pulses at
// 16x the bit rate. The receive FSM samples each bit at its middle and
// hands a correctly framed byte to uart_led with a one-cycle strobe.
//
// Optional feature: define UART_RX_PARITY_EN to add an even-parity bit
// between the data bits and the stop bit. This also adds the par_err port.
//
// Parameters:
//   CLOCK_RATE   clk_rx frequency in Hz
//   BAUD_RATE    serial bit rate in baud
//
// Ports:
//   clk_rx       in   receive clock; all logic runs on its rising edge
//   rst_clk_rx   in   synchronous, active-high reset
//   rxd_clk_rx   in   synchronized RXD; idles high
//   rx_data      out  [7:0] last correctly framed byte
//   rx_data_rdy  out  one-cycle strobe; rx_data is new in this cycle
//   frm_err      out  one-cycle strobe; the stop bit was sampled low
//   par_err      out  (UART_RX_PARITY_EN only) one-cycle strobe on parity mismatch

module uart_rx #(
    parameter int CLOCK_RATE = 200_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk_rx,
    input  logic       rst_clk_rx,
    input  logic       rxd_clk_rx,
    output logic [7:0] rx_data,
    output logic       rx_data_rdy,
`ifdef UART_RX_PARITY_EN
    output logic       frm_err,
    output logic       par_err
`else
    output logic       frm_err
`endif
);

    // Divisor for the 16x enable, rounded to the nearest integer.
    localparam longint DIV_L = (longint'(CLOCK_RATE) + longint'(BAUD_RATE) * 8)
                               / (longint'(BAUD_RATE) * 16);
    localparam int     DIV   = int'(DIV_L);
    localparam int     CNT_W = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);

    if (DIV < 2) begin : g_div_too_small
        $error("uart_rx: baud divisor must be at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [3:0]       over_cnt_q, over_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rxd_q;
    logic             rdy_q, rdy_d;
    logic             frm_q, frm_d;
`ifdef UART_RX_PARITY_EN
    logic             par_q, par_d;
    logic             par_bad_q, par_bad_d;
`endif

    logic baud_x16_en;
    logic start_edge;
    logic tick_half;   // 8th tick of the start bit: middle of the start bit
    logic tick_full;   // 16th tick of a bit: middle of the current bit

    // The baud enable runs continuously; frames are aligned by over_cnt
    // alone, so the edge-to-first-tick phase varies by up to one tick.
    assign baud_x16_en = (baud_cnt_q == DIV_LAST);
    assign baud_cnt_d  = baud_x16_en ? '0 : baud_cnt_q + CNT_W'(1);

    // Only a true high-to-low transition starts a frame, so a line stuck
    // low (break, or after a framing error) is ignored until it goes high.
    assign start_edge = rxd_q && !rxd_clk_rx;
    assign tick_half  = baud_x16_en && (over_cnt_q == 4'd7);
    assign tick_full  = baud_x16_en && (over_cnt_q == 4'd15);

    // State register and datapath registers that need a defined reset.
    always_ff @(posedge clk_rx) begin
        if (rst_clk_rx) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            over_cnt_q <= '0;
            bit_cnt_q  <= '0;
            rxd_q      <= 1'b1;
            rx_data_q  <= 8'h00;
            rdy_q      <= 1'b0;
            frm_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q      <= 1'b0;
            par_bad_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            over_cnt_q <= over_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            rxd_q      <= rxd_clk_rx;
            rx_data_q  <= rx_data_d;
            rdy_q      <= rdy_d;
            frm_q      <= frm_d;
`ifdef UART_RX_PARITY_EN
            par_q      <= par_d;
            par_bad_q  <= par_bad_d;
`endif
        end
    end

    // The shift register is fully overwritten by every frame before it is
    // ever copied to rx_data, so it carries no reset.
    always_ff @(posedge clk_rx) begin
        shift_q <= shift_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_edge) state_d = S_START;
            end
            S_START: begin
                // A start bit that is high again at mid-bit was a glitch.
                if (tick_half) state_d = rxd_clk_rx ? S_IDLE : S_DATA;
            end
            S_DATA: begin
`ifdef UART_RX_PARITY_EN
                if (tick_full && bit_cnt_q == 3'd7) state_d = S_PARITY;
`else
                if (tick_full && bit_cnt_q == 3'd7) state_d = S_STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick_full) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (tick_full) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Counter, shift register and strobe logic.
    always_comb begin
        over_cnt_d = over_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        rdy_d      = 1'b0;
        frm_d      = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d      = 1'b0;
        par_bad_d  = par_bad_q;
`endif
        case (state_q)
            S_IDLE: begin
                over_cnt_d = '0;
                bit_cnt_d  = '0;
            end
            S_START: begin
                if (tick_half) begin
                    // Restart the oversample count so that data samples
                    // fall 16 ticks apart from the middle of the start bit.
                    over_cnt_d = '0;
                    bit_cnt_d  = '0;
                end else if (baud_x16_en) begin
                    over_cnt_d = over_cnt_q + 4'd1;
                end
            end
            S_DATA: begin
                if (baud_x16_en) over_cnt_d = over_cnt_q + 4'd1;
                if (tick_full) begin
                    // LSB arrives first, so bits enter at the top and move down.
                    shift_d = {rxd_clk_rx, shift_q[7:1]};
                    if (bit_cnt_q != 3'd7) bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (baud_x16_en) over_cnt_d = over_cnt_q + 4'd1;
                // Even parity: data bits plus parity bit XOR to zero.
                if (tick_full) par_bad_d = (^shift_q) ^ rxd_clk_rx;
            end
`endif
            S_STOP: begin
                if (baud_x16_en) over_cnt_d = over_cnt_q + 4'd1;
                if (tick_full) begin
                    if (!rxd_clk_rx) begin
                        frm_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (par_bad_q) begin
                        par_d = 1'b1;
`endif
                    end else begin
                        rdy_d     = 1'b1;
                        rx_data_d = shift_q;
                    end
                end
            end
            default: begin
                over_cnt_d = '0;
                bit_cnt_d  = '0;
            end
        endcase
    end

    assign rx_data     = rx_data_q;
    assign rx_data_rdy = rdy_q;
    assign frm_err     = frm_q;
`ifdef UART_RX_PARITY_EN
    assign par_err     = par_q;
`endif

endmodule
